// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, classifies each
// full scan frame and debounces the frame results into a calculator key code.
module keypad_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] usrin,
    output logic       keystrobe
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] DB_MAX = 4'(DEBOUNCE);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    logic [3:0]       cols_meta;
    logic [3:0]       cols_sync;
    logic [DIV_W-1:0] div;
    logic [1:0]       row_idx;
    logic [1:0]       acc_keys;
    logic [3:0]       acc_code;
    logic [3:0]       frame_f;
    logic             frame_valid;
    logic [1:0]       state;
    logic [3:0]       cand;
    logic [3:0]       cnt;

    logic       sample;
    logic [3:0] pressed;
    logic [2:0] row_keys;
    logic [3:0] row_code;
    logic [2:0] sum_keys;
    logic [1:0] frame_keys;
    logic [3:0] frame_code;
    logic [3:0] cnt_inc;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = 4'd11;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = 4'd12;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = 4'd13;
            4'hC: code = 4'd15;
            4'hD: code = 4'd10;
            4'hE: code = 4'd0;
            default: code = 4'd14;
        endcase
        return code;
    endfunction

    // acc_keys saturates at 2: only "none", "exactly one" and "several" matter.
    always_comb begin
        sample   = (div == DIV_LAST);
        pressed  = ~cols_sync;
        row_keys = '0;
        row_code = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            if (pressed[c]) begin
                row_keys = row_keys + 3'd1;
                row_code = key_code(row_idx, 2'(c));
            end
        end
        sum_keys   = {1'b0, acc_keys} + row_keys;
        frame_keys = (sum_keys >= 3'd2) ? 2'd2 : sum_keys[1:0];
        frame_code = (row_keys == 3'd1) ? row_code : acc_code;
        cnt_inc    = cnt + 4'd1;
        rows       = ~(4'b0001 << row_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cols_meta   <= '1;
            cols_sync   <= '1;
            div         <= '0;
            row_idx     <= '0;
            acc_keys    <= '0;
            acc_code    <= '0;
            frame_f     <= '0;
            frame_valid <= 1'b0;
            state       <= IDLE;
            cand        <= '0;
            cnt         <= '0;
            usrin       <= '0;
            keystrobe   <= 1'b0;
        end else begin
            cols_meta   <= cols;
            cols_sync   <= cols_meta;
            frame_valid <= 1'b0;
            keystrobe   <= 1'b0;

            if (sample) begin
                div     <= '0;
                row_idx <= row_idx + 2'd1;
                if (row_idx == 2'd3) begin
                    frame_f     <= (frame_keys == 2'd1) ? frame_code : 4'd0;
                    frame_valid <= 1'b1;
                    acc_keys    <= '0;
                    acc_code    <= '0;
                end else begin
                    acc_keys <= frame_keys;
                    acc_code <= frame_code;
                end
            end else begin
                div <= div + DIV_W'(1);
            end

            if (frame_valid) begin
                case (state)
                    IDLE: begin
                        if (frame_f != 4'd0) begin
                            state <= PRESS_WAIT;
                            cand  <= frame_f;
                            cnt   <= 4'd1;
                        end
                    end
                    PRESS_WAIT: begin
                        if (frame_f == 4'd0) begin
                            state <= IDLE;
                        end else if (frame_f == cand) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == DB_MAX) begin
                                state     <= HELD;
                                usrin     <= cand;
                                keystrobe <= 1'b1;
                            end
                        end else begin
                            cand <= frame_f;
                            cnt  <= 4'd1;
                        end
                    end
                    HELD: begin
                        if (frame_f != cand) begin
                            state <= RELEASE_WAIT;
                            cnt   <= (frame_f == 4'd0) ? 4'd1 : 4'd0;
                        end
                    end
                    default: begin
                        // A different key while releasing restarts the release count.
                        if (frame_f == 4'd0) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == DB_MAX) begin
                                state <= IDLE;
                                usrin <= '0;
                            end
                        end else if (frame_f == cand) begin
                            state <= HELD;
                        end else begin
                            cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: passive keypad matrix model driven by key masks,
// compared every cycle against a frame-level reference model.
module tb_keypad_scanner;
    localparam int D     = 4;
    localparam int DB    = 3;
    localparam int FRAME = 4 * D;

    localparam logic [15:0] K1 = 16'h0001;
    localparam logic [15:0] K2 = 16'h0002;
    localparam logic [15:0] K3 = 16'h0004;
    localparam logic [15:0] K4 = 16'h0010;
    localparam logic [15:0] K5 = 16'h0020;
    localparam logic [15:0] K7 = 16'h0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [3:0]  usrin;
    logic        keystrobe;
    logic [15:0] keys;

    int checks  = 0;
    int passes  = 0;
    int strobes = 0;
    bit run_checks = 1'b0;

    // Key codes by matrix position 4*row+col.
    int code_of [16] = '{1, 2, 3, 11, 4, 5, 6, 12, 7, 8, 9, 13, 15, 10, 0, 14};

    keypad_scanner #(.SCAN_DIV(D), .DEBOUNCE(DB)) dut (
        .clk(clk),
        .rst(rst),
        .cols(cols),
        .rows(rows),
        .usrin(usrin),
        .keystrobe(keystrobe)
    );

    always #5 clk = ~clk;

    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && rows[r] === 1'b0) cols[c] = 1'b0;
    end

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic check_n(input string tag, input int obs, input int exp);
        checks = checks + 1;
        assert (obs == exp) passes = passes + 1;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic wait_usrin(input logic [3:0] v, input int budget, input string tag);
        int n = 0;
        while (usrin !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check4(tag, usrin, v);
    endtask

    // Reference model: each row is read with the key state from two clocks
    // before its sample edge; a frame yields the code of its only pressed key.
    int          t = 0;
    int          mr;
    logic [15:0] h0, h1, h2, fmask;
    bit          pend = 1'b0;
    int          f_pend = 0;
    int          held = 0, cand = 0, run = 0, zrun = 0;
    logic [3:0]  exp_usrin = '0;
    logic        exp_strobe = 1'b0;
    logic [3:0]  exp_rows = 4'b1110;

    function automatic int frame_result(input logic [15:0] m);
        int n = 0;
        int code = 0;
        for (int i = 0; i < 16; i++)
            if (m[i]) begin
                n++;
                code = code_of[i];
            end
        return (n == 1) ? code : 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t = 0; h0 = '0; h1 = '0; h2 = '0; fmask = '0; pend = 1'b0;
            held = 0; cand = 0; run = 0; zrun = 0;
            exp_usrin = '0; exp_strobe = 1'b0; exp_rows = 4'b1110;
        end else begin
            exp_strobe = 1'b0;
            h2 = h1; h1 = h0; h0 = keys;
            if (pend) begin
                pend = 1'b0;
                if (held == 0) begin
                    if (f_pend == 0) begin
                        cand = 0; run = 0;
                    end else if (f_pend == cand) begin
                        run++;
                        if (run >= DB) begin
                            held = cand; zrun = 0; exp_strobe = 1'b1;
                        end
                    end else begin
                        cand = f_pend; run = 1;
                    end
                end else if (f_pend == held) begin
                    zrun = 0;
                end else if (f_pend == 0) begin
                    zrun++;
                    if (zrun >= DB) begin
                        held = 0; cand = 0; run = 0; zrun = 0;
                    end
                end else begin
                    zrun = 0;
                end
                exp_usrin = 4'(held);
            end
            if (t % D == D - 1) begin
                mr = (t / D) % 4;
                fmask[4*mr +: 4] = h2[4*mr +: 4];
                if (mr == 3) begin
                    f_pend = frame_result(fmask);
                    pend   = 1'b1;
                    fmask  = '0;
                end
            end
            t++;
            exp_rows = ~(4'b0001 << ((t / D) % 4));
        end
    end

    always @(negedge clk) begin
        if (run_checks) begin
            check4("usrin", usrin, exp_usrin);
            check4("keystrobe", {3'b000, keystrobe}, {3'b000, exp_strobe});
            check4("rows", rows, exp_rows);
            if (keystrobe === 1'b1) strobes++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        logic [15:0] m;
        rst  = 1'b1;
        keys = '0;
        repeat (2) @(negedge clk);
        run_checks = 1'b1;
        check4("reset_usrin", usrin, 4'd0);
        check4("reset_rows", rows, 4'b1110);
        check4("reset_keystrobe", {3'b000, keystrobe}, 4'd0);

        // '5' held from reset release; edge 0 is the next rising edge.
        keys = K5;
        rst  = 1'b0;
        repeat (48) @(negedge clk);
        check4("t1_before_edge48", usrin, 4'd0);
        @(negedge clk);
        check4("t1_usrin_edge48", usrin, 4'd5);
        check4("t1_strobe_edge48", {3'b000, keystrobe}, 4'd1);
        @(negedge clk);
        check4("t1_strobe_edge49", {3'b000, keystrobe}, 4'd0);
        s = strobes;
        repeat (5 * FRAME) @(negedge clk);
        check4("t1_held", usrin, 4'd5);

        keys = '0;
        wait_usrin(4'd0, 6 * FRAME, "t2_release");
        repeat (2) @(negedge clk);
        check_n("t2_no_release_strobe", strobes - s, 0);
        repeat (2 * FRAME) @(negedge clk);

        // Bounce with random phase, then a clean hold.
        s = strobes;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        for (int i = 0; i < (2 * FRAME) / 5; i++) begin
            keys = keys ^ K5;
            repeat (5) @(negedge clk);
        end
        keys = K5;
        wait_usrin(4'd5, 6 * FRAME, "t3_accept");
        repeat (2) @(negedge clk);
        check_n("t3_single_strobe", strobes - s, 1);
        keys = '0;
        repeat (FRAME) @(negedge clk);
        keys = K5;
        repeat (3 * FRAME) @(negedge clk);
        check4("t3_dropout_held", usrin, 4'd5);
        check_n("t3_dropout_no_strobe", strobes - s, 1);
        keys = '0;
        wait_usrin(4'd0, 8 * FRAME, "t3_release");
        repeat (FRAME) @(negedge clk);

        for (int k = 0; k < 16; k++) begin
            s = strobes;
            keys = '0;
            keys[k] = 1'b1;
            repeat (6 * FRAME) @(negedge clk);
            check4("t4_keymap", usrin, 4'(code_of[k]));
            check_n("t4_strobes", strobes - s, (k == 14) ? 0 : 1);
            keys = '0;
            repeat (6 * FRAME) @(negedge clk);
            check4("t4_release", usrin, 4'd0);
        end

        s = strobes;
        keys = K1 | K2;
        repeat (6 * FRAME) @(negedge clk);
        check4("t5_two_keys", usrin, 4'd0);
        check_n("t5_two_keys_strobe", strobes - s, 0);
        keys = '0;
        repeat (2 * FRAME) @(negedge clk);
        keys = K3;
        wait_usrin(4'd3, 6 * FRAME, "t5_accept3");
        repeat (FRAME) @(negedge clk);
        keys = K3 | K4;
        repeat (FRAME) @(negedge clk);
        keys = K3;
        repeat (3 * FRAME) @(negedge clk);
        check4("t5_overlap_keeps3", usrin, 4'd3);
        s = strobes;
        keys = K4;
        repeat (6 * FRAME) @(negedge clk);
        check4("t5_no_switch", usrin, 4'd3);
        check_n("t5_no_switch_strobe", strobes - s, 0);
        keys = '0;
        wait_usrin(4'd0, 8 * FRAME, "t5_release");
        repeat (FRAME) @(negedge clk);
        keys = K4;
        wait_usrin(4'd4, 6 * FRAME, "t5_fresh4");
        keys = '0;
        wait_usrin(4'd0, 8 * FRAME, "t5_release4");

        keys = K7;
        wait_usrin(4'd7, 6 * FRAME, "t6_accept7");
        repeat (FRAME) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check4("t6_usrin", usrin, 4'd0);
        check4("t6_rows", rows, 4'b1110);
        check4("t6_strobe", {3'b000, keystrobe}, 4'd0);
        repeat (48) @(negedge clk);
        check4("t6_before_edge48", usrin, 4'd0);
        @(negedge clk);
        check4("t6_reaccept", usrin, 4'd7);
        check4("t6_reaccept_strobe", {3'b000, keystrobe}, 4'd1);
        keys = '0;
        wait_usrin(4'd0, 8 * FRAME, "t6_release");

        for (int i = 0; i < 10; i++) begin
            m = '0;
            m[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 3) == 0) m[$urandom_range(0, 15)] = 1'b1;
            keys = m;
            repeat ($urandom_range(FRAME, 8 * FRAME)) @(negedge clk);
            keys = '0;
            repeat ($urandom_range(D, 6 * FRAME)) @(negedge clk);
        end
        keys = '0;
        repeat (8 * FRAME) @(negedge clk);
        check4("final_idle", usrin, 4'd0);

        run_checks = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
